// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard detection, operand forwarding and pipeline control for the
// five-stage IF/ID/EXE/MEM/WB core.
//
// A scoreboard shadows the destination registers of instructions between ID and
// register-file write. Every cycle it is compared against the sources of the ID
// instruction to decide load-use/RAW stalls and the forwarding selects for the next
// EXE cycle. Branch flush and memory-wait freeze are also issued from here.
//
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   id_*                fields of the instruction currently in ID
//   br_taken            branch in EXE is taken
//   mem_ready           data memory completes this cycle (0 = wait)
//   stall_if            hold PC and IF/ID
//   bubble_id           write a NOP into ID/EXE
//   flush               invalidate IF/ID, PC loads branch target
//   freeze              hold every stage register and the PC
//   fwd_sel1/2          EXE operand source: 0 ID/EXE, 1 MEM ALU result, 2 WB data
//   stall_cnt/flush_cnt saturating activity counters
module pipe_hazard_ctrl #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned DEPTH      = 3,
    parameter bit          FWD_EN     = 1'b1,
    parameter int unsigned COUNT_W    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_src1,
    input  logic [REG_ADDR_W-1:0] id_src2,
    input  logic                  id_use_src2,
    input  logic [REG_ADDR_W-1:0] id_dest,
    input  logic                  id_wb_en,
    input  logic                  id_mem_r,
    input  logic                  br_taken,
    input  logic                  mem_ready,
    output logic                  stall_if,
    output logic                  bubble_id,
    output logic                  flush,
    output logic                  freeze,
    output logic [1:0]            fwd_sel1,
    output logic [1:0]            fwd_sel2,
    output logic [COUNT_W-1:0]    stall_cnt,
    output logic [COUNT_W-1:0]    flush_cnt
);

    // The WB entry (DEPTH-1) can never cause a hazard thanks to the write-through
    // register file, so it is only kept when it doubles as the forwarding source of
    // entry 1 (DEPTH == 2). At least two entries are needed for the select logic.
    localparam int unsigned NumEntries = (DEPTH > 2) ? DEPTH - 1 : 2;

    logic [NumEntries-1:0] sb_valid_q;
    logic [NumEntries-1:0] sb_wb_en_q;
    logic [REG_ADDR_W-1:0] sb_dest_q [NumEntries];
    // Only the EXE entry's load flag matters: older loads have their data by then.
    logic                  sb_mem_r_q;

    logic [1:0]            fwd_sel1_q, fwd_sel2_q;
    logic [1:0]            fwd_sel1_d, fwd_sel2_d;
    logic [COUNT_W-1:0]    stall_cnt_q, flush_cnt_q;

    logic [NumEntries-1:0] match1, match2;
    logic                  hazard;

    // Source-vs-entry matches; r0 never matches.
    always_comb begin
        match1 = '0;
        match2 = '0;
        for (int k = 0; k < int'(NumEntries); k++) begin
            match1[k] = sb_valid_q[k] & sb_wb_en_q[k] & (id_src1 != '0) &
                        (sb_dest_q[k] == id_src1);
            match2[k] = sb_valid_q[k] & sb_wb_en_q[k] & id_use_src2 & (id_src2 != '0) &
                        (sb_dest_q[k] == id_src2);
        end
    end

    always_comb begin
        hazard = 1'b0;
        if (FWD_EN) begin
            // EXE producer is forwardable unless it is a load; MEM producer is forwarded
            // from WB; anything older than that (deep pipelines) must wait.
            if ((match1[0] | match2[0]) & sb_mem_r_q) begin
                hazard = 1'b1;
            end
            for (int k = 2; k < int'(DEPTH) - 1; k++) begin
                if (match1[k] | match2[k]) begin
                    hazard = 1'b1;
                end
            end
        end else begin
            for (int k = 0; k < int'(DEPTH) - 1; k++) begin
                if (match1[k] | match2[k]) begin
                    hazard = 1'b1;
                end
            end
        end
    end

    // Priority freeze > flush > stall; all forced low while in reset.
    assign freeze    = rst & ~mem_ready;
    assign flush     = rst & br_taken & ~freeze;
    assign stall_if  = rst & hazard & id_valid & ~flush & ~freeze;
    assign bubble_id = stall_if | flush;

    // Youngest producer wins: EXE entry (next cycle in MEM) before MEM entry (next in WB).
    always_comb begin
        fwd_sel1_d = 2'd0;
        fwd_sel2_d = 2'd0;
        if (FWD_EN) begin
            if (match1[0] && !sb_mem_r_q) begin
                fwd_sel1_d = 2'd1;
            end else if (match1[1]) begin
                fwd_sel1_d = 2'd2;
            end
            if (match2[0] && !sb_mem_r_q) begin
                fwd_sel2_d = 2'd1;
            end else if (match2[1]) begin
                fwd_sel2_d = 2'd2;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sb_valid_q  <= '0;
            sb_wb_en_q  <= '0;
            sb_mem_r_q  <= 1'b0;
            for (int k = 0; k < int'(NumEntries); k++) begin
                sb_dest_q[k] <= '0;
            end
            fwd_sel1_q  <= 2'd0;
            fwd_sel2_q  <= 2'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else if (!freeze) begin
            for (int k = 1; k < int'(NumEntries); k++) begin
                sb_valid_q[k] <= sb_valid_q[k-1];
                sb_wb_en_q[k] <= sb_wb_en_q[k-1];
                sb_dest_q[k]  <= sb_dest_q[k-1];
            end
            sb_valid_q[0] <= id_valid & ~bubble_id;
            sb_wb_en_q[0] <= id_wb_en;
            sb_dest_q[0]  <= id_dest;
            sb_mem_r_q    <= id_mem_r;

            fwd_sel1_q <= bubble_id ? 2'd0 : fwd_sel1_d;
            fwd_sel2_q <= bubble_id ? 2'd0 : fwd_sel2_d;

            if (stall_if && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + COUNT_W'(1);
            end
            if (flush && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + COUNT_W'(1);
            end
        end
    end

    assign fwd_sel1  = fwd_sel1_q;
    assign fwd_sel2  = fwd_sel2_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl. Three instances share one stimulus:
//   0: DEPTH=3 forwarding, 1: DEPTH=3 stall-only, 2: DEPTH=4 forwarding with 4-bit counters.
// A reference model tracks the in-flight instructions of each instance as records.
module tb_pipe_hazard_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, id_valid, id_use_src2, id_wb_en, id_mem_r, br_taken, mem_ready;
    logic [4:0] id_src1, id_src2, id_dest;

    logic [2:0]  o_stall, o_bub, o_flush, o_frz;
    logic [1:0]  o_sel1 [3];
    logic [1:0]  o_sel2 [3];
    logic [15:0] c0_s, c0_f, c1_s, c1_f;
    logic [3:0]  c2_s, c2_f;
    logic [15:0] o_scnt [3];
    logic [15:0] o_fcnt [3];

    always_comb begin
        o_scnt[0] = c0_s;
        o_scnt[1] = c1_s;
        o_scnt[2] = {12'd0, c2_s};
        o_fcnt[0] = c0_f;
        o_fcnt[1] = c1_f;
        o_fcnt[2] = {12'd0, c2_f};
    end

    pipe_hazard_ctrl #(.REG_ADDR_W(5), .DEPTH(3), .FWD_EN(1'b1), .COUNT_W(16)) u_fwd (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
        .id_use_src2(id_use_src2), .id_dest(id_dest), .id_wb_en(id_wb_en),
        .id_mem_r(id_mem_r), .br_taken(br_taken), .mem_ready(mem_ready),
        .stall_if(o_stall[0]), .bubble_id(o_bub[0]), .flush(o_flush[0]), .freeze(o_frz[0]),
        .fwd_sel1(o_sel1[0]), .fwd_sel2(o_sel2[0]), .stall_cnt(c0_s), .flush_cnt(c0_f)
    );

    pipe_hazard_ctrl #(.REG_ADDR_W(5), .DEPTH(3), .FWD_EN(1'b0), .COUNT_W(16)) u_stall (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
        .id_use_src2(id_use_src2), .id_dest(id_dest), .id_wb_en(id_wb_en),
        .id_mem_r(id_mem_r), .br_taken(br_taken), .mem_ready(mem_ready),
        .stall_if(o_stall[1]), .bubble_id(o_bub[1]), .flush(o_flush[1]), .freeze(o_frz[1]),
        .fwd_sel1(o_sel1[1]), .fwd_sel2(o_sel2[1]), .stall_cnt(c1_s), .flush_cnt(c1_f)
    );

    pipe_hazard_ctrl #(.REG_ADDR_W(5), .DEPTH(4), .FWD_EN(1'b1), .COUNT_W(4)) u_deep (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
        .id_use_src2(id_use_src2), .id_dest(id_dest), .id_wb_en(id_wb_en),
        .id_mem_r(id_mem_r), .br_taken(br_taken), .mem_ready(mem_ready),
        .stall_if(o_stall[2]), .bubble_id(o_bub[2]), .flush(o_flush[2]), .freeze(o_frz[2]),
        .fwd_sel1(o_sel1[2]), .fwd_sel2(o_sel2[2]), .stall_cnt(c2_s), .flush_cnt(c2_f)
    );

    int n_vec = 0;
    int n_err = 0;

    // ---------------- reference model ----------------
    typedef struct {
        bit         v;
        bit         wb;
        bit         ld;
        logic [4:0] dst;
    } instr_t;

    int     cfg_depth [3] = '{3, 3, 4};
    bit     cfg_fwd   [3] = '{1'b1, 1'b0, 1'b1};
    int     cfg_max   [3] = '{65535, 65535, 15};
    instr_t pipe      [3][4];   // [inst][0] = instruction in EXE
    int     m_sel1 [3];
    int     m_sel2 [3];
    int     m_sc   [3];
    int     m_fc   [3];

    function automatic bit reads(int i, int k, logic [4:0] s, bit inuse);
        return inuse && (s != 5'd0) && pipe[i][k].v && pipe[i][k].wb && (pipe[i][k].dst == s);
    endfunction

    function automatic bit hits(int i, int k);
        return reads(i, k, id_src1, 1'b1) || reads(i, k, id_src2, id_use_src2);
    endfunction

    function automatic bit exp_hazard(int i);
        for (int k = 0; k <= cfg_depth[i] - 2; k++) begin
            if (hits(i, k)) begin
                if (!cfg_fwd[i]) return 1'b1;
                if (k == 0 && pipe[i][0].ld) return 1'b1;
                if (k >= 2) return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    function automatic bit exp_freeze();
        return rst && !mem_ready;
    endfunction

    function automatic bit exp_flush();
        return rst && br_taken && mem_ready;
    endfunction

    function automatic bit exp_stall(int i);
        return rst && id_valid && exp_hazard(i) && !br_taken && mem_ready;
    endfunction

    function automatic int pick(int i, logic [4:0] s, bit inuse);
        if (!cfg_fwd[i]) return 0;
        if (reads(i, 0, s, inuse) && !pipe[i][0].ld) return 1;
        if (reads(i, 1, s, inuse)) return 2;
        return 0;
    endfunction

    // ---------------- sequencing helpers (no comparisons) ----------------
    task automatic settle();
        @(negedge clk);
    endtask

    // Update the model with the current (stable) inputs, then take the clock edge.
    task automatic advance();
        for (int i = 0; i < 3; i++) begin
            if (!rst) begin
                for (int k = 0; k < 4; k++) pipe[i][k].v = 1'b0;
                m_sel1[i] = 0;
                m_sel2[i] = 0;
                m_sc[i]   = 0;
                m_fc[i]   = 0;
            end else if (mem_ready) begin
                bit st, bub;
                st  = exp_stall(i);
                bub = st || exp_flush();
                m_sel1[i] = bub ? 0 : pick(i, id_src1, 1'b1);
                m_sel2[i] = bub ? 0 : pick(i, id_src2, id_use_src2);
                if (st && m_sc[i] < cfg_max[i]) m_sc[i]++;
                if (exp_flush() && m_fc[i] < cfg_max[i]) m_fc[i]++;
                for (int k = 3; k >= 1; k--) pipe[i][k] = pipe[i][k-1];
                pipe[i][0] = '{v: id_valid && !bub, wb: id_wb_en, ld: id_mem_r, dst: id_dest};
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid = 0; id_src1 = 0; id_src2 = 0; id_use_src2 = 0;
        id_dest = 0; id_wb_en = 0; id_mem_r = 0; br_taken = 0; mem_ready = 1;
    endtask

    task automatic instr(int s1, int s2, bit u2, int d, bit wb, bit ld);
        id_valid = 1; id_src1 = 5'(s1); id_src2 = 5'(s2); id_use_src2 = u2;
        id_dest = 5'(d); id_wb_en = wb; id_mem_r = ld; br_taken = 0; mem_ready = 1;
    endtask

    task automatic do_reset();
        idle();
        rst = 0;
        settle();
        advance();
        rst = 1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 0;
        instr(1, 1, 1, 1, 1, 1);
        br_taken = 1; mem_ready = 0;
        settle();
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if ({o_stall[i], o_bub[i], o_flush[i], o_frz[i]} !== 4'b0000) begin
                n_err++;
                $display("FAIL reset_comb inst%0d: got stall/bub/flush/frz=%b%b%b%b want 0000",
                         i, o_stall[i], o_bub[i], o_flush[i], o_frz[i]);
            end
        end
        advance();
        settle();
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (o_sel1[i] !== 2'd0 || o_sel2[i] !== 2'd0 || o_scnt[i] !== 16'd0 ||
                o_fcnt[i] !== 16'd0) begin
                n_err++;
                $display("FAIL reset_regs inst%0d: got sel=%0d/%0d cnt=%0d/%0d want all 0",
                         i, o_sel1[i], o_sel2[i], o_scnt[i], o_fcnt[i]);
            end
        end
        advance();
        rst = 1;
    endtask

    task automatic test_fwd_exe();
        do_reset();
        instr(1, 2, 1, 3, 1, 0);           // ADD r3,r1,r2
        advance();
        instr(3, 1, 1, 4, 1, 0);           // SUB r4,r3,r1
        settle();
        n_vec++;
        if (o_stall[0] !== 1'b0) begin
            n_err++; $display("FAIL fwd_exe_stall: got %b want 0", o_stall[0]);
        end
        advance();
        idle();
        settle();
        n_vec++;
        if (o_sel1[0] !== 2'd1 || o_sel2[0] !== 2'd0) begin
            n_err++; $display("FAIL fwd_exe_sel: got %0d/%0d want 1/0", o_sel1[0], o_sel2[0]);
        end
        advance();
    endtask

    task automatic test_load_use();
        do_reset();
        instr(1, 0, 0, 5, 1, 1);           // LD r5
        advance();
        instr(5, 5, 1, 6, 1, 0);           // ADD r6,r5,r5
        settle();
        n_vec++;
        if (o_stall[0] !== 1'b1 || o_bub[0] !== 1'b1) begin
            n_err++; $display("FAIL load_use_stall: got %b/%b want 1/1", o_stall[0], o_bub[0]);
        end
        advance();
        settle();
        n_vec++;
        if (o_stall[0] !== 1'b0 || o_bub[0] !== 1'b0) begin
            n_err++; $display("FAIL load_use_release: got %b/%b want 0/0", o_stall[0], o_bub[0]);
        end
        advance();
        idle();
        settle();
        n_vec++;
        if (o_sel1[0] !== 2'd2 || o_sel2[0] !== 2'd2 || o_scnt[0] !== 16'd1) begin
            n_err++;
            $display("FAIL load_use_sel: got sel=%0d/%0d cnt=%0d want 2/2 cnt=1",
                     o_sel1[0], o_sel2[0], o_scnt[0]);
        end
        advance();
    endtask

    task automatic test_stall_only();
        do_reset();
        instr(1, 0, 0, 2, 1, 0);           // ADD r2
        advance();
        instr(2, 0, 1, 7, 1, 0);           // ADD r7,r2,r0
        for (int c = 0; c < 3; c++) begin
            settle();
            n_vec++;
            if (o_stall[1] !== ((c < 2) ? 1'b1 : 1'b0)) begin
                n_err++;
                $display("FAIL stall_only_c%0d: got %b want %b", c, o_stall[1], c < 2);
            end
            advance();
        end
        idle();
        settle();
        n_vec++;
        if (o_sel1[1] !== 2'd0 || o_sel2[1] !== 2'd0 || o_scnt[1] !== 16'd2) begin
            n_err++;
            $display("FAIL stall_only_end: got sel=%0d/%0d cnt=%0d want 0/0 cnt=2",
                     o_sel1[1], o_sel2[1], o_scnt[1]);
        end
        advance();
    endtask

    task automatic test_branch_hazard();
        do_reset();
        instr(1, 0, 0, 5, 1, 1);           // LD r5
        advance();
        instr(5, 5, 1, 6, 1, 0);           // ADD r6,r5,r5 (load-use) under taken branch
        br_taken = 1;
        settle();
        n_vec++;
        if (o_flush[0] !== 1'b1 || o_stall[0] !== 1'b0 || o_bub[0] !== 1'b1) begin
            n_err++;
            $display("FAIL br_hazard: got flush/stall/bub=%b/%b/%b want 1/0/1",
                     o_flush[0], o_stall[0], o_bub[0]);
        end
        advance();
        instr(6, 5, 1, 9, 1, 0);           // reads discarded r6 and the load's r5
        settle();
        n_vec++;
        if (o_stall[0] !== 1'b0) begin
            n_err++; $display("FAIL br_next_stall: got %b want 0", o_stall[0]);
        end
        advance();
        idle();
        settle();
        n_vec++;
        if (o_sel1[0] !== 2'd0 || o_sel2[0] !== 2'd2 || o_fcnt[0] !== 16'd1 ||
            o_scnt[0] !== 16'd0) begin
            n_err++;
            $display("FAIL br_after: got sel=%0d/%0d flush_cnt=%0d stall_cnt=%0d want 0/2 1 0",
                     o_sel1[0], o_sel2[0], o_fcnt[0], o_scnt[0]);
        end
        advance();
    endtask

    task automatic test_freeze();
        do_reset();
        instr(1, 2, 1, 3, 1, 0);           // ADD r3
        advance();
        instr(3, 0, 0, 4, 1, 0);
        br_taken = 1;
        mem_ready = 0;
        for (int c = 0; c < 3; c++) begin
            settle();
            n_vec++;
            if (o_frz[0] !== 1'b1 || o_flush[0] !== 1'b0 || o_stall[0] !== 1'b0) begin
                n_err++;
                $display("FAIL freeze_c%0d: got frz/flush/stall=%b/%b/%b want 1/0/0",
                         c, o_frz[0], o_flush[0], o_stall[0]);
            end
            advance();
        end
        mem_ready = 1;
        settle();
        n_vec++;
        if (o_frz[0] !== 1'b0 || o_flush[0] !== 1'b1 || o_bub[0] !== 1'b1) begin
            n_err++;
            $display("FAIL freeze_release: got frz/flush/bub=%b/%b/%b want 0/1/1",
                     o_frz[0], o_flush[0], o_bub[0]);
        end
        advance();
        instr(3, 0, 0, 8, 1, 0);           // ADD r3 must still be in flight (now MEM)
        settle();
        advance();
        idle();
        settle();
        n_vec++;
        if (o_sel1[0] !== 2'd2 || o_fcnt[0] !== 16'd1) begin
            n_err++;
            $display("FAIL freeze_held: got sel1=%0d flush_cnt=%0d want 2 1",
                     o_sel1[0], o_fcnt[0]);
        end
        advance();
    endtask

    task automatic test_depth();
        do_reset();
        instr(1, 0, 0, 3, 1, 0);
        advance();
        idle();
        advance();
        advance();
        instr(3, 0, 0, 4, 1, 0);           // producer now in entry 2
        settle();
        n_vec++;
        if (o_stall !== 3'b100) begin
            n_err++; $display("FAIL depth_entry2: got stall=%b want 100", o_stall);
        end
        advance();
    endtask

    task automatic test_r0_reset();
        do_reset();
        instr(1, 0, 0, 0, 1, 1);           // LD r0
        advance();
        instr(0, 0, 1, 7, 1, 0);
        settle();
        n_vec++;
        if (o_stall !== 3'b000) begin
            n_err++; $display("FAIL r0_nostall: got %b want 000", o_stall);
        end
        advance();
        instr(1, 0, 0, 5, 1, 1);           // LD r5
        advance();
        instr(5, 0, 0, 6, 1, 0);
        settle();
        n_vec++;
        if (o_stall[0] !== 1'b1) begin
            n_err++; $display("FAIL r0_midstall: got %b want 1", o_stall[0]);
        end
        advance();
        rst = 0;
        settle();
        n_vec++;
        if ({o_stall[0], o_bub[0], o_flush[0], o_frz[0]} !== 4'b0000) begin
            n_err++;
            $display("FAIL r0_rst_comb: got %b%b%b%b want 0000",
                     o_stall[0], o_bub[0], o_flush[0], o_frz[0]);
        end
        advance();
        rst = 1;
        settle();
        n_vec++;
        if (o_stall[0] !== 1'b0 || o_scnt[0] !== 16'd0 || o_sel1[0] !== 2'd0) begin
            n_err++;
            $display("FAIL r0_rst_after: got stall=%b cnt=%0d sel1=%0d want 0 0 0",
                     o_stall[0], o_scnt[0], o_sel1[0]);
        end
        advance();
    endtask

    task automatic test_saturation();
        do_reset();
        br_taken = 1;
        for (int c = 0; c < 20; c++) advance();
        settle();
        n_vec++;
        if (o_fcnt[2] !== 16'd15 || o_fcnt[0] !== 16'd20) begin
            n_err++;
            $display("FAIL saturation: got %0d/%0d want 15/20", o_fcnt[2], o_fcnt[0]);
        end
        advance();
        idle();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            rst         = ($urandom_range(0, 63) != 0);
            id_valid    = ($urandom_range(0, 3) != 0);
            id_src1     = 5'($urandom_range(0, 7));
            id_src2     = 5'($urandom_range(0, 7));
            id_use_src2 = 1'($urandom_range(0, 1));
            id_dest     = 5'($urandom_range(0, 7));
            id_wb_en    = ($urandom_range(0, 3) != 0);
            id_mem_r    = ($urandom_range(0, 2) == 0);
            br_taken    = ($urandom_range(0, 7) == 0);
            mem_ready   = ($urandom_range(0, 5) != 0);
            settle();
            for (int i = 0; i < 3; i++) begin
                bit es, ef, ez;
                es = exp_stall(i);
                ef = exp_flush();
                ez = exp_freeze();
                n_vec++;
                if ({o_stall[i], o_bub[i], o_flush[i], o_frz[i]} !== {es, es | ef, ef, ez}) begin
                    n_err++;
                    $display("FAIL rand_comb c%0d inst%0d: got %b%b%b%b want %b%b%b%b", c, i,
                             o_stall[i], o_bub[i], o_flush[i], o_frz[i], es, es | ef, ef, ez);
                end
                n_vec++;
                if (o_sel1[i] !== 2'(m_sel1[i]) || o_sel2[i] !== 2'(m_sel2[i])) begin
                    n_err++;
                    $display("FAIL rand_sel c%0d inst%0d: got %0d/%0d want %0d/%0d", c, i,
                             o_sel1[i], o_sel2[i], m_sel1[i], m_sel2[i]);
                end
                n_vec++;
                if (o_scnt[i] !== 16'(m_sc[i]) || o_fcnt[i] !== 16'(m_fc[i])) begin
                    n_err++;
                    $display("FAIL rand_cnt c%0d inst%0d: got %0d/%0d want %0d/%0d", c, i,
                             o_scnt[i], o_fcnt[i], m_sc[i], m_fc[i]);
                end
            end
            advance();
        end
        rst = 1;
        idle();
    endtask

    initial begin
        idle();
        rst = 0;
        for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < 4; k++) pipe[i][k] = '{v: 1'b0, wb: 1'b0, ld: 1'b0, dst: 5'd0};
            m_sel1[i] = 0; m_sel2[i] = 0; m_sc[i] = 0; m_fc[i] = 0;
        end
        test_reset();
        test_fwd_exe();
        test_load_use();
        test_stall_only();
        test_branch_hazard();
        test_freeze();
        test_depth();
        test_r0_reset();
        test_saturation();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Parametrised hazard, forwarding and pipeline-control unit for the five-stage IF/ID/EXE/MEM/WB core. It keeps a scoreboard of in-flight destination registers and issues all pipeline-wide control from one place: load-use and RAW stalls, operand-forwarding selects, branch flush and memory-wait freeze. It sits beside the ID stage and drives the hold/flush controls of the PC and of the IF/ID, ID/EXE, EXE/MEM and MEM/WB stage registers. Saturating performance counters record stall and flush activity.

## Interface
- REG_ADDR_W, 5, register-address width; register 0 is hard-wired zero.
- DEPTH, 3, stages between ID and register-file write (EXE, MEM, WB); minimum 2.
- FWD_EN, 1, 1 = forwarding mode; 0 = stall-only mode.
- COUNT_W, 16, performance-counter width.

- clk  in  1  clock; every flop updates on the rising edge.
- rst  in  1  synchronous, active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_src1, id_src2  in  REG_ADDR_W  source register addresses.
- id_use_src2  in  1  the instruction reads src2.
- id_dest  in  REG_ADDR_W  destination register.
- id_wb_en  in  1  the instruction writes back.
- id_mem_r  in  1  the instruction is a load.
- br_taken  in  1  the branch currently in EXE is taken.
- mem_ready  in  1  data memory completes this cycle; 0 means wait.
- stall_if  out  1  hold the PC and IF/ID.
- bubble_id  out  1  write a NOP into ID/EXE.
- flush  out  1  invalidate IF/ID; the PC loads the branch target.
- freeze  out  1  hold every stage register and the PC.
- fwd_sel1, fwd_sel2  out  2  operand source for the instruction in EXE: 0 = ID/EXE value, 1 = MEM-stage ALU result, 2 = WB data, 3 = unused.
- stall_cnt, flush_cnt  out  COUNT_W  saturating counters.

## Operation
- Scoreboard: DEPTH entries of {valid, wb_en, mem_r, dest}. Entry 0 is the instruction in EXE; entry DEPTH-1 is the instruction in WB.
- Match on source s against entry k: the entry is valid, has wb_en=1, s is non-zero, dest == s, and s is in use (src1 is always in use; src2 only when id_use_src2=1).
- Matches against entry DEPTH-1 are never a hazard, because the register file is write-through (same-cycle write bypass).
- Hazard when FWD_EN=1:
  - any source matches entry 0 and entry 0 has mem_r=1 (load-use), or
  - any source matches an entry in 2..DEPTH-2.
- Hazard when FWD_EN=0: any source matches any entry in 0..DEPTH-2.
- Combinational outputs:
  - freeze = ~mem_ready.
  - flush = br_taken & ~freeze.
  - stall_if = hazard & id_valid & ~flush & ~freeze.
  - bubble_id = stall_if | flush.
- Priority, highest first: freeze, flush, stall.
- Scoreboard advance, when freeze=0: entry k takes entry k-1 for k>=1. Entry 0 takes the ID fields, or is cleared to valid=0 when bubble_id=1 or id_valid=0. When freeze=1 all entries hold.
- Forwarding selects are registered and are loaded only when an instruction issues (freeze=0, bubble_id=0), per source:
  - a match in entry 0 (non-load) gives 1;
  - otherwise a match in entry 1 gives 2;
  - otherwise 0.
  - The youngest match wins.
  - When FWD_EN=0 the selects are always 0.
  - On a bubble the selects load 0.
- Counters:
  - stall_cnt increments on every cycle with stall_if=1.
  - flush_cnt increments on every cycle with flush=1.
  - Both saturate at all-ones and hold while frozen.

## Timing
- Reset, applied on a rising edge while rst=0: scoreboard valid bits = 0, fwd_sel1 = fwd_sel2 = 0, stall_cnt = flush_cnt = 0.
- While rst=0 the combinational outputs are forced: stall_if = bubble_id = flush = freeze = 0.
- stall_if, bubble_id, flush and freeze are combinational, valid in the same cycle as their inputs, with 0 cycles of latency.
- fwd_sel is valid in the cycle after issue, aligned with the instruction now in EXE.
- Load-use costs exactly one stall cycle. After it the load is in entry 1 and fwd_sel = 2.
- Simultaneous br_taken and hazard: only the flush occurs, stall_cnt does not increment, and the ID instruction is discarded.
- br_taken during freeze: flush is deferred, and it fires in the first cycle with mem_ready=1 (EXE holds br_taken stable).
- Reset in mid-stall or mid-freeze: on the next edge all in-flight hazards are lost and the scoreboard is empty.

## Test plan
- Forwarding from EXE: ADD r3 then SUB r4,r3,r1 back-to-back, FWD_EN=1. Required: no stall; fwd_sel1 = 1 in the SUB EXE cycle.
- Load-use: LD r5 then ADD r6,r5,r5. Required: stall_if = bubble_id = 1 for exactly one cycle; then fwd_sel1 = fwd_sel2 = 2; stall_cnt = 1.
- Stall-only mode: FWD_EN=0, ADD r2 then ADD r7,r2,r0, DEPTH=3. Required: two stall cycles; fwd_sel stays 0; stall_cnt = 2.
- Branch over hazard: br_taken=1 in the same cycle as a load-use hazard. Required: flush = 1, stall_if = 0, flush_cnt = 1, stall_cnt unchanged; entry 0 is invalid next cycle.
- Freeze: mem_ready=0 for 3 cycles with br_taken=1. Required: freeze = 1 and flush = 0 for those 3 cycles; flush = 1 on the 4th; the scoreboard is unchanged across the freeze.
- r0 and reset: writes to r0 never stall. Drive rst=0 mid-stall. Required: the next cycle shows all outputs at 0, counters at 0 and the scoreboard empty.
